// File: rtl/cla16_sub_pipe_if.sv
// Operand/result bundle for the pipelined 16-bit CLA subtractor.
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high; the sender holds its payload stable while valid && !ready, and
// ready may depend combinationally on the receiver's state.
interface cla16_sub_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] d;
  logic        bout;
  logic        ovf;
  logic        zero;

  // Producer/consumer side: drives operands and accepts results.
  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, d, bout, ovf, zero
  );

  // Subtractor side.
  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, d, bout, ovf, zero
  );
endinterface

// File: rtl/cla16_sub_pipe.sv
// 16-bit subtractor d = a - b - bin built as a + ~b + ~bin, split into four
// 4-bit carry-lookahead slices with one pipeline stage per slice. The whole
// pipe advances together unless a finished result is waiting on out_ready.
module cla16_sub_pipe (
  input  logic             clk,
  input  logic             rst_n,
  cla16_sub_pipe_if.slave  bus
);

  // One 4-bit lookahead slice: returns {carry_out, sum[3:0]}; y is ~b.
  function automatic logic [4:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                      input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic       c1, c2, c3, c4;
    g  = x & y;
    p  = x ^ y;
    c1 = g[0] | (p[0] & ci);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c4, p ^ {c3, c2, c1, ci}};
  endfunction

  // Stage k keeps its carry-out, the finished low difference bits and the
  // operand bits that later slices still need.
  logic [3:0]  v_q, v_d;
  logic        c0_q, c0_d, c1_q, c1_d, c2_q, c2_d;
  logic [3:0]  d0_q, d0_d;
  logic [7:0]  d1_q, d1_d;
  logic [11:0] d2_q, d2_d;
  logic [15:4] a0_q, a0_d, b0_q, b0_d;
  logic [15:8] a1_q, a1_d, b1_q, b1_d;
  logic [15:12] a2_q, a2_d, b2_q, b2_d;
  logic [15:0] d_q, d_d;
  logic        bout_q, bout_d, ovf_q, ovf_d, zero_q, zero_d;

  logic        stall;
  logic [4:0]  s0, s1, s2, s3;
  logic [15:0] d_full;

  // Slice adders feeding each stage, plus the global stall.
  always_comb begin
    stall  = v_q[3] && !bus.out_ready;
    s0     = cla4(bus.a[3:0], ~bus.b[3:0], ~bus.bin);
    s1     = cla4(a0_q[7:4], ~b0_q[7:4], c0_q);
    s2     = cla4(a1_q[11:8], ~b1_q[11:8], c1_q);
    s3     = cla4(a2_q[15:12], ~b2_q[15:12], c2_q);
    d_full = {s3[3:0], d2_q};
  end

  // Next-state: everything shifts one stage unless stalled; payload registers
  // only load behind a valid bit so bubbles leave the outputs untouched.
  always_comb begin
    v_d    = v_q;
    c0_d   = c0_q;  d0_d = d0_q;  a0_d = a0_q;  b0_d = b0_q;
    c1_d   = c1_q;  d1_d = d1_q;  a1_d = a1_q;  b1_d = b1_q;
    c2_d   = c2_q;  d2_d = d2_q;  a2_d = a2_q;  b2_d = b2_q;
    d_d    = d_q;
    bout_d = bout_q;
    ovf_d  = ovf_q;
    zero_d = zero_q;
    if (!stall) begin
      v_d = {v_q[2:0], bus.in_valid};
      if (bus.in_valid) begin
        c0_d = s0[4];
        d0_d = s0[3:0];
        a0_d = bus.a[15:4];
        b0_d = bus.b[15:4];
      end
      if (v_q[0]) begin
        c1_d = s1[4];
        d1_d = {s1[3:0], d0_q};
        a1_d = a0_q[15:8];
        b1_d = b0_q[15:8];
      end
      if (v_q[1]) begin
        c2_d = s2[4];
        d2_d = {s2[3:0], d1_q};
        a2_d = a1_q[15:12];
        b2_d = b1_q[15:12];
      end
      if (v_q[2]) begin
        d_d    = d_full;
        bout_d = ~s3[4];
        ovf_d  = (a2_q[15] != b2_q[15]) && (d_full[15] != a2_q[15]);
        zero_d = (d_full == 16'h0000);
      end
    end
  end

  // Pipeline registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      c0_q   <= 1'b0;  d0_q <= '0;  a0_q <= '0;  b0_q <= '0;
      c1_q   <= 1'b0;  d1_q <= '0;  a1_q <= '0;  b1_q <= '0;
      c2_q   <= 1'b0;  d2_q <= '0;  a2_q <= '0;  b2_q <= '0;
      d_q    <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      v_q    <= v_d;
      c0_q   <= c0_d;  d0_q <= d0_d;  a0_q <= a0_d;  b0_q <= b0_d;
      c1_q   <= c1_d;  d1_q <= d1_d;  a1_q <= a1_d;  b1_q <= b1_d;
      c2_q   <= c2_d;  d2_q <= d2_d;  a2_q <= a2_d;  b2_q <= b2_d;
      d_q    <= d_d;
      bout_q <= bout_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign bus.in_ready  = !stall;
  assign bus.out_valid = v_q[3];
  assign bus.d         = d_q;
  assign bus.bout      = bout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_cla16_sub_pipe.sv
// Directed bench for cla16_sub_pipe: hand-computed vectors go into an
// expected queue as they are accepted; a monitor pops and compares results.
module tb_cla16_sub_pipe;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;

  cla16_sub_pipe_if bus ();

  cla16_sub_pipe dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock/reset block and edge counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: {d, bout, ovf, zero} and expected output cycle (-1 = skip).
  logic [18:0] exp_q[$];
  int          lat_q[$];

  task automatic check(input string name, input logic [18:0] got, input logic [18:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
    end
  endtask

  // Driver: present one operand set (at posedge+1) until accepted.
  task automatic send(input logic [15:0] a_i, input logic [15:0] b_i, input logic bin_i,
                      input logic [15:0] ed, input logic eb, input logic eo, input logic ez,
                      input logic lat_chk);
    int n;
    bus.in_valid = 1'b1;
    bus.a        = a_i;
    bus.b        = b_i;
    bus.bin      = bin_i;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n >= 50) begin
      bad++;
      $display("FAIL accept_timeout a=%h b=%h", a_i, b_i);
    end
    @(posedge clk); #1;
    exp_q.push_back({ed, eb, eo, ez});
    lat_q.push_back(lat_chk ? cyc + 3 : -1);
    bus.in_valid = 1'b0;
  endtask

  // Monitor: every delivered result is compared against the queue head.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result d=%h want=none", bus.d);
      end else begin
        logic [18:0] e;
        int          l;
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        check("result", {bus.d, bus.bout, bus.ovf, bus.zero}, e);
        if (l >= 0) check("latency_cycle", 19'(cyc), 19'(l));
      end
    end
  end

  initial begin
    int  n;
    logic seen;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 19'(bus.out_valid), 19'd0);
    check("reset_outputs", {bus.d, bus.bout, bus.ovf, bus.zero}, 19'd0);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", 19'(bus.in_ready), 19'd1);
    @(posedge clk); #1;

    // Single operations with idle gaps.
    send(16'h0003, 16'h0003, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (5) @(posedge clk); #1;
    send(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1);
    send(16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b1);
    send(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    send(16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (6) @(posedge clk); #1;

    // Back-to-back burst of four.
    send(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1);
    send(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    send(16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0, 1'b0, 1'b1);
    send(16'h1000, 16'h0FFF, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (6) @(posedge clk); #1;
    check("burst_drained", 19'(exp_q.size()), 19'd0);

    // Backpressure: first result held for three cycles, second behind it.
    bus.out_ready = 1'b0;
    send(16'h00F0, 16'h000F, 1'b0, 16'h00E1, 1'b0, 1'b0, 1'b0, 1'b0);
    send(16'h0100, 16'h0200, 1'b0, 16'hFF00, 1'b1, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 10) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall_out_valid", 19'(bus.out_valid), 19'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stall_hold", {bus.d, bus.out_valid, bus.in_ready, 1'b0}, {16'h00E1, 1'b1, 1'b0, 1'b0});
    end
    bus.out_ready = 1'b1;
    repeat (4) @(posedge clk); #1;
    check("stall_drained", 19'(exp_q.size()), 19'd0);

    // Reset with two operations in flight.
    send(16'h2222, 16'h1111, 1'b0, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b1);
    send(16'h3333, 16'h1111, 1'b0, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    lat_q.delete();
    #1;
    check("midreset_outputs", {bus.d, bus.bout, bus.ovf, bus.zero}, 19'd0);
    check("midreset_out_valid", 19'(bus.out_valid), 19'd0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("no_stale_after_reset", 19'(seen), 19'd0);
    @(posedge clk); #1;
    send(16'h4000, 16'hC000, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1);

    // Drain with a bounded wait.
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("final_drain", 19'(exp_q.size()), 19'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
